// File: rtl/win3x3_sched.sv
// Raster-order 3x3 window scheduler with two line buffers and border substitution.
// Define WIN_REPLICATE_EN to clamp out-of-image neighbours to the nearest edge pixel instead of using pad.
module win3x3_sched #(
    parameter int IMG_W = 300,
    parameter int IMG_H = 400,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] pad,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic [DW-1:0] w0,
    output logic [DW-1:0] w1,
    output logic [DW-1:0] w2,
    output logic [DW-1:0] w3,
    output logic [DW-1:0] w4,
    output logic [DW-1:0] w5,
    output logic [DW-1:0] w6,
    output logic [DW-1:0] w7,
    output logic [DW-1:0] w8,
    output logic          w_valid,
    input  logic          w_ready,
    output logic          busy,
    output logic          frame_done
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int FW = $clog2(IMG_W + 2);
    localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] R_ONE  = RW'(1);
    localparam logic [FW-1:0] F_END  = FW'(IMG_W + 1);
    localparam logic [FW-1:0] F_ONE  = FW'(1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_in_c, r_o_c;
    logic [RW-1:0]   r_in_r, r_o_r;
    logic [FW-1:0]   r_fcnt;
    logic            r_wv;
    logic [DW-1:0]   r_pad;
    logic [DW-1:0]   r_win [9];
    logic [DW-1:0]   r_lb0 [IMG_W];
    logic [DW-1:0]   r_lb1 [IMG_W];
    logic [DW-1:0]   w_win [9];
    logic [DW-1:0]   w_col_new;
    logic            w_step, w_hs, w_last, w_srdy;
    logic            w_top, w_bot, w_lft, w_rgt;

    assign w_hs   = r_wv && w_ready;
    assign w_last = (r_o_r == R_LAST) && (r_o_c == C_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_srdy      = 1'b0;
        w_step      = 1'b0;
        w_col_new   = s_data;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_FILL;
            end
            S_FILL: begin
                w_srdy = 1'b1;
                w_step = s_valid;
                if (s_valid && (r_in_r == R_ONE) && (r_in_c == '0)) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_srdy = !r_wv || w_ready;
                w_step = s_valid && w_srdy;
                if (w_step && (r_in_r == R_LAST) && (r_in_c == C_LAST)) w_state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                // Rows below the image enter as pad; the border mux hides them anyway.
                w_col_new = r_pad;
                w_step    = (r_fcnt != F_END) && (!r_wv || w_ready);
                if (w_hs && w_last) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_in_c  <= '0;
            r_in_r  <= '0;
            r_o_c   <= '0;
            r_o_r   <= '0;
            r_fcnt  <= '0;
            r_wv    <= 1'b0;
            r_pad   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE) begin
                if (start) begin
                    r_pad  <= pad;
                    r_in_c <= '0;
                    r_in_r <= '0;
                    r_o_c  <= '0;
                    r_o_r  <= '0;
                    r_fcnt <= '0;
                    r_wv   <= 1'b0;
                end
            end else begin
                if (w_step) begin
                    r_in_c <= (r_in_c == C_LAST) ? '0 : r_in_c + C_ONE;
                    if (r_state == S_FLUSH)
                        r_fcnt <= r_fcnt + F_ONE;
                    else if (r_in_c == C_LAST)
                        r_in_r <= (r_in_r == R_LAST) ? '0 : r_in_r + R_ONE;
                end
                if (w_step && (r_state != S_FILL))
                    r_wv <= 1'b1;
                else if (w_hs)
                    r_wv <= 1'b0;
                if (w_hs) begin
                    r_o_c <= (r_o_c == C_LAST) ? '0 : r_o_c + C_ONE;
                    if (r_o_c == C_LAST) r_o_r <= (r_o_r == R_LAST) ? '0 : r_o_r + R_ONE;
                end
            end
        end
    end

    // New right column: two rows from the line buffers plus the incoming pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) r_win[i] <= '0;
        end else if (w_step) begin
            for (int r = 0; r < 3; r++) begin
                r_win[r*3]   <= r_win[r*3+1];
                r_win[r*3+1] <= r_win[r*3+2];
            end
            r_win[2] <= r_lb0[r_in_c];
            r_win[5] <= r_lb1[r_in_c];
            r_win[8] <= w_col_new;
        end
    end

    always_ff @(posedge clk) begin
        if (w_step) begin
            r_lb0[r_in_c] <= r_lb1[r_in_c];
            r_lb1[r_in_c] <= w_col_new;
        end
    end

    assign w_top = (r_o_r == '0);
    assign w_bot = (r_o_r == R_LAST);
    assign w_lft = (r_o_c == '0);
    assign w_rgt = (r_o_c == C_LAST);

    for (genvar g = 0; g < 9; g++) begin : g_mux
        localparam int ROW = g / 3;
        localparam int COL = g % 3;
        logic w_rsel, w_csel;
        assign w_rsel = ((ROW == 0) && w_top) || ((ROW == 2) && w_bot);
        assign w_csel = ((COL == 0) && w_lft) || ((COL == 2) && w_rgt);
`ifdef WIN_REPLICATE_EN
        // Clamp toward the centre row/column, which always lies inside the image.
        assign w_win[g] = w_rsel ? (w_csel ? r_win[4] : r_win[3+COL])
                                 : (w_csel ? r_win[ROW*3+1] : r_win[g]);
`else
        assign w_win[g] = (w_rsel || w_csel) ? r_pad : r_win[g];
`endif
    end

    assign w0 = w_win[0];
    assign w1 = w_win[1];
    assign w2 = w_win[2];
    assign w3 = w_win[3];
    assign w4 = w_win[4];
    assign w5 = w_win[5];
    assign w6 = w_win[6];
    assign w7 = w_win[7];
    assign w8 = w_win[8];

    assign s_ready    = w_srdy;
    assign w_valid    = r_wv;
    assign busy       = (r_state != S_IDLE);
    assign frame_done = w_hs && w_last && (r_state == S_FLUSH);

endmodule

// File: tb/tb_win3x3_sched.sv
// Scoreboard bench for win3x3_sched on a 4x3 image with s_data = k and pad = 100.
module tb_win3x3_sched;
    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic       clk, rst_n, start, s_valid, s_ready, w_valid, w_ready, busy, frame_done;
    logic [7:0] pad, s_data;
    logic [7:0] w0, w1, w2, w3, w4, w5, w6, w7, w8;

    win3x3_sched #(.IMG_W(W), .IMG_H(H), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pad(pad),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .w0(w0), .w1(w1), .w2(w2), .w3(w3), .w4(w4), .w5(w5), .w6(w6), .w7(w7), .w8(w8),
        .w_valid(w_valid), .w_ready(w_ready), .busy(busy), .frame_done(frame_done)
    );

    typedef struct packed {
        logic [71:0] win;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    logic [71:0] cap [64];
    int          cap_n, fd_n, checks, errors;
    logic        tog_mode;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        w_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            w_ready = tog_mode ? !w_ready : 1'b1;
        end
    end

    function automatic logic [71:0] pk9(input int a0, input int a1, input int a2,
                                        input int a3, input int a4, input int a5,
                                        input int a6, input int a7, input int a8);
        return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    function automatic logic [71:0] model_win(input int ctr);
        logic [71:0] v;
        int r, c, rr, cc;
        v = '0;
        r = ctr / W;
        c = ctr % W;
        for (int i = 0; i < 9; i++) begin
            rr = r + i / 3 - 1;
            cc = c + i % 3 - 1;
`ifdef WIN_REPLICATE_EN
            if (rr < 0) rr = 0;
            if (rr > H - 1) rr = H - 1;
            if (cc < 0) cc = 0;
            if (cc > W - 1) cc = W - 1;
            v[i*8 +: 8] = 8'(rr * W + cc);
`else
            if (rr < 0 || rr >= H || cc < 0 || cc >= W) v[i*8 +: 8] = 8'd100;
            else v[i*8 +: 8] = 8'(rr * W + cc);
`endif
        end
        return v;
    endfunction

    task automatic chkw(input string nm, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic logic [71:0] cur_win();
        return {w8, w7, w6, w5, w4, w3, w2, w1, w0};
    endfunction

    task automatic push_input(input int k);
        exp_t e;
        if (k >= W + 1) begin
            e.win  = model_win(k - W - 1);
            e.last = 1'b0;
            sb.push_back(e);
        end
        if (k == N - 1) begin
            for (int c = N - W - 1; c < N; c++) begin
                e.win  = model_win(c);
                e.last = (c == N - 1);
                sb.push_back(e);
            end
        end
    endtask

    task automatic monitor();
        logic        prev_stall, prev_fd;
        logic [71:0] prev_win;
        exp_t        e;
        prev_stall = 1'b0;
        prev_fd    = 1'b0;
        prev_win   = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (prev_stall) begin
                    chk1("stall_valid", w_valid, 1'b1);
                    chkw("stall_hold", cur_win(), prev_win);
                end
                if (prev_fd) begin
                    chk1("busy_fall", busy, 1'b0);
                    chk1("frame_done_pulse", frame_done, 1'b0);
                end
                if (w_valid && !w_ready) chk1("stall_s_ready", s_ready, 1'b0);
                if (w_valid && w_ready) begin
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL extra_window actual=%h required=none", cur_win());
                    end else begin
                        e = sb.pop_front();
                        chkw("window", cur_win(), e.win);
                        chk1("frame_done", frame_done, e.last);
                        if (cap_n < 64) cap[cap_n] = cur_win();
                        cap_n++;
                    end
                end else if (frame_done) begin
                    errors++;
                    $display("FAIL frame_done_no_hs actual=1 required=0");
                end
                if (frame_done) begin
                    fd_n++;
                    chk1("busy_at_done", busy, 1'b1);
                end
                prev_stall = w_valid && !w_ready;
                prev_fd    = frame_done;
                prev_win   = cur_win();
            end else begin
                prev_stall = 1'b0;
                prev_fd    = 1'b0;
            end
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk1({tag, "_s_ready"}, s_ready, 1'b0);
        chk1({tag, "_w_valid"}, w_valid, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_frame_done"}, frame_done, 1'b0);
        chkw({tag, "_window"}, cur_win(), 72'h0);
    endtask

    task automatic start_frame();
        cap_n = 0;
        fd_n  = 0;
        @(posedge clk); #1;
        start = 1'b1;
        pad   = 8'd100;
        @(negedge clk);
        chk1("s_ready_before_start", s_ready, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        pad   = 8'd55;
        @(negedge clk);
        chk1("s_ready_after_start", s_ready, 1'b1);
        chk1("busy_after_start", busy, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic drive_frame(input int gap, input int stop_after, input int glitch_at);
        int   k, gl, t;
        logic acc;
        k = 0; gl = 0; t = 0;
        s_valid = 1'b1;
        s_data  = 8'd0;
        while (k < stop_after && t < 600) begin
            @(negedge clk);
            acc = s_valid && s_ready;
            if (acc) begin
                push_input(k);
                k++;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (acc) begin
                s_data = 8'(k);
                if (k == glitch_at) begin
                    start = 1'b1;
                    pad   = 8'd7;
                end
                if (gap > 0 && k > W + 1 && k < stop_after) begin
                    gl      = gap;
                    s_valid = 1'b0;
                end else begin
                    s_valid = (k < stop_after);
                end
            end else if (gl > 0) begin
                gl--;
                if (gl == 0) s_valid = 1'b1;
            end
            t++;
        end
        s_valid = 1'b0;
        start   = 1'b0;
        chk1("drive_in_budget", t < 600, 1'b1);
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while ((sb.size() != 0 || busy) && t < 300) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk1({tag, "_end_in_budget"}, t < 300, 1'b1);
        chki({tag, "_window_count"}, cap_n, N);
        chki({tag, "_frame_done_count"}, fd_n, 1);
    endtask

    task automatic check_consts(input string tag);
`ifdef WIN_REPLICATE_EN
        chkw({tag, "_win0"},  cap[0],  pk9(0, 0, 1, 0, 0, 1, 4, 4, 5));
        chkw({tag, "_win5"},  cap[5],  pk9(0, 1, 2, 4, 5, 6, 8, 9, 10));
        chkw({tag, "_win11"}, cap[11], pk9(6, 7, 7, 10, 11, 11, 10, 11, 11));
`else
        chkw({tag, "_win0"},  cap[0],  pk9(100, 100, 100, 100, 0, 1, 100, 4, 5));
        chkw({tag, "_win5"},  cap[5],  pk9(0, 1, 2, 4, 5, 6, 8, 9, 10));
        chkw({tag, "_win11"}, cap[11], pk9(6, 7, 100, 10, 11, 100, 100, 100, 100));
`endif
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        cap_n    = 0;
        fd_n     = 0;
        tog_mode = 1'b0;
        rst_n    = 1'b0;
        start    = 1'b0;
        pad      = 8'd0;
        s_valid  = 1'b0;
        s_data   = 8'd0;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;

        start_frame();
        drive_frame(0, N, -1);
        wait_done("full");
        check_consts("full");

        tog_mode = 1'b1;
        start_frame();
        drive_frame(0, N, -1);
        wait_done("backpressure");
        check_consts("backpressure");
        tog_mode = 1'b0;

        start_frame();
        drive_frame(3, N, -1);
        wait_done("gaps");
        check_consts("gaps");

        start_frame();
        drive_frame(0, 7, -1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midreset");
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk1("idle_after_reset_busy", busy, 1'b0);
        chk1("idle_after_reset_s_ready", s_ready, 1'b0);
        start_frame();
        drive_frame(0, N, -1);
        wait_done("after_reset");
        check_consts("after_reset");

        start_frame();
        drive_frame(0, N, 7);
        wait_done("start_glitch");
        check_consts("start_glitch");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/win3x3_sched.md
# win3x3_sched

Raster-order 3x3 neighbourhood scheduler that feeds the image filter stage (`sel` = 2 path). It accepts one grayscale pixel per handshake, keeps two line buffers and a 3x3 register window, and presents `w0`..`w8` in raster order of the centre pixel. Out-of-image neighbours are replaced by a per-frame pad value. It sits between the grayscale converter output and the 9-input filter datapath, and takes over window sequencing from the bench.

## Interface
- `IMG_W`, 300, pixels per row (≥ 3)
- `IMG_H`, 400, rows per frame (≥ 2)
- `DW`, 8, pixel width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  begin frame; sampled only in IDLE
- `pad`  in  DW  border value; captured on accepted `start`
- `s_valid`  in  1  input pixel valid
- `s_ready`  out  1  input pixel accepted when `s_valid && s_ready`
- `s_data`  in  DW  input pixel, raster order
- `w0`..`w8`  out  DW each  window: `w0..w2` row r-1 (c-1, c, c+1); `w3..w5` row r; `w6..w8` row r+1
- `w_valid`  out  1  window valid
- `w_ready`  in  1  window consumed when `w_valid && w_ready`
- `busy`  out  1  high from accepted `start` until the last window handshake
- `frame_done`  out  1  one-cycle pulse on the last window handshake

## Operation
- N = IMG_W*IMG_H. Input index k = r*IMG_W + c. The window for centre k is produced once input k+IMG_W+1 is accepted, or during FLUSH for k ≥ N-IMG_W-1.
- FSM:
  - IDLE: `start` → FILL; `pad` latched; all counters cleared.
  - FILL: accept the first IMG_W+1 pixels; no windows are emitted. `s_ready` = 1. After input IMG_W (0-based) is accepted → RUN.
  - RUN: each accepted input emits exactly one window. After input N-1 is accepted → FLUSH.
  - FLUSH: `s_ready` = 0. Emit the remaining IMG_W+1 windows without input. After the last window handshake → IDLE; `frame_done` pulses.
- Storage:
  - Two IMG_W-deep line buffers, each DW wide. Each is written and read once per input or flush step.
  - A 3x3 shift window. Rows past the end of the image are filled with `pad` during FLUSH.
- Border substitution is a mux on the output registers, selected by the centre (r,c) counters: r=0 → top row; r=IMG_H-1 → bottom row; c=0 → left column; c=IMG_W-1 → right column. No wrap-around between rows: column 0 never sees data from the previous row's last column.
- Counters: input r/c and output r/c, sized `$clog2` of the respective dimension. Column wraps at IMG_W-1 and increments the row.
- `start` while not IDLE is ignored. `pad` changes mid-frame are ignored.

## Timing
- Reset values: `s_ready` 0, `w_valid` 0, `w0`..`w8` 0, `busy` 0, `frame_done` 0, FSM IDLE, all counters 0.
- `s_ready` rises the cycle after an accepted `start`.
- In RUN: `s_ready` = !`w_valid` || `w_ready` (no skid buffer). When `s_valid` is high throughout, `w_valid` asserts the cycle after the triggering input handshake, for 1-cycle latency and 1 window/cycle throughput.
- `w_valid` and `w0`..`w8` are held stable while `w_valid && !w_ready`.
- FLUSH: one window per cycle while `w_ready` = 1.
- `frame_done` and `busy` fall in the same cycle, in the cycle after the final handshake.
- `rst_n` low mid-frame: immediate return to IDLE with reset values. Partial-frame data is discarded. The next frame needs a new `start`.

## Configuration
- `WIN_REPLICATE_EN` defined: out-of-image neighbours take the nearest edge pixel (coordinate clamp), and `pad` is ignored.
- Not defined: out-of-image neighbours equal the latched `pad`.

## Test plan
All scenarios use IMG_W=4, IMG_H=3, `s_data` = k, pad=100.
- Full frame, `w_ready`=1: window 0 = 100,100,100,100,0,1,100,4,5; window 5 = 0,1,2,4,5,6,8,9,10; window 11 = 6,7,100,10,11,100,100,100,100. 12 windows total, `frame_done` single pulse.
- Backpressure: `w_ready` toggles 1/0 each cycle. Outputs are stable while stalled, `s_ready` is low while stalled, and the window sequence is identical to the previous scenario.
- `s_valid` gaps of 3 cycles in RUN: no duplicated or dropped windows; FLUSH still emits exactly 5 windows.
- `rst_n` pulsed after 7 inputs, then a new `start`: the second frame is correct with no residue from the first.
- `start` pulsed during RUN: ignored. With `WIN_REPLICATE_EN`, window 0 = 0,0,1,0,0,1,4,4,5 and window 11 = 6,7,7,10,11,11,10,11,11.
